// File: rtl/ex_wb_elastic.sv
// Elastic EX->WB pipeline register: main + skid entry, registered in_ready, sync flush.
// Define EX_WB_FWD_EN to add combinational forwarding ports fed from the main entry.
module ex_wb_elastic #(
   parameter int DATA_W   = 8,
   parameter int RADDR_W  = 3,
   parameter int ZERO_REG = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_regwrite,
   input  logic [RADDR_W-1:0] in_reg,
   input  logic [DATA_W-1:0]  in_result,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_regwrite,
   output logic [RADDR_W-1:0] out_reg,
   output logic [DATA_W-1:0]  out_result
`ifdef EX_WB_FWD_EN
   ,
   input  logic [RADDR_W-1:0] src_a,
   input  logic [RADDR_W-1:0] src_b,
   output logic               fwd_a_hit,
   output logic               fwd_b_hit,
   output logic [DATA_W-1:0]  fwd_a_data,
   output logic [DATA_W-1:0]  fwd_b_data
`endif
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t               state;
   logic                 main_we, skid_we;
   logic [RADDR_W-1:0]   main_reg, skid_reg;
   logic [DATA_W-1:0]    main_result, skid_result;
   logic                 accept, in_we;

   // in_ready is already 0 in TWO, so accept never fires there
   assign accept = in_valid & in_ready;
   assign in_we  = in_regwrite & ~((ZERO_REG != 0) && (in_reg == '0));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= EMPTY;
         in_ready    <= 1'b1;
         main_we     <= 1'b0;
         main_reg    <= '0;
         main_result <= '0;
         skid_we     <= 1'b0;
         skid_reg    <= '0;
         skid_result <= '0;
      end else if (flush) begin
         state    <= EMPTY;
         in_ready <= 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  main_we     <= in_we;
                  main_reg    <= in_reg;
                  main_result <= in_result;
                  state       <= ONE;
               end
            end
            ONE: begin
               if (accept && out_ready) begin
                  main_we     <= in_we;
                  main_reg    <= in_reg;
                  main_result <= in_result;
               end else if (accept) begin
                  skid_we     <= in_we;
                  skid_reg    <= in_reg;
                  skid_result <= in_result;
                  state       <= TWO;
                  in_ready    <= 1'b0;
               end else if (out_ready) begin
                  state <= EMPTY;
               end
            end
            TWO: begin
               if (out_ready) begin
                  main_we     <= skid_we;
                  main_reg    <= skid_reg;
                  main_result <= skid_result;
                  state       <= ONE;
                  in_ready    <= 1'b1;
               end
            end
            default: begin
               state    <= EMPTY;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

   assign out_valid    = (state != EMPTY);
   assign out_regwrite = out_valid & main_we;
   assign out_reg      = main_reg;
   assign out_result   = main_result;

`ifdef EX_WB_FWD_EN
   logic zero_a, zero_b;

   // Skid entry is never forwarded; hazard logic stalls EX while in_ready=0
   assign zero_a     = (ZERO_REG != 0) && (src_a == '0);
   assign zero_b     = (ZERO_REG != 0) && (src_b == '0);
   assign fwd_a_hit  = out_regwrite & (out_reg == src_a) & ~zero_a;
   assign fwd_b_hit  = out_regwrite & (out_reg == src_b) & ~zero_b;
   assign fwd_a_data = fwd_a_hit ? out_result : '0;
   assign fwd_b_data = fwd_b_hit ? out_result : '0;
`endif

endmodule

// File: tb/tb_ex_wb_elastic.sv
// Scoreboard bench for ex_wb_elastic: reset, streaming, backpressure, flush, r0, forwarding.
module tb_ex_wb_elastic;

   typedef struct packed {
      logic       we;
      logic [2:0] rd;
      logic [7:0] res;
   } entry_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_regwrite = 1'b0;
   logic [2:0] in_reg = '0;
   logic [7:0] in_result = '0;
   logic       out_ready = 1'b0;
   logic [2:0] src_a = '0;
   logic [2:0] src_b = '0;

   logic       in_ready, out_valid, out_regwrite;
   logic [2:0] out_reg;
   logic [7:0] out_result;
   logic       in_ready1, out_valid1, out_regwrite1;
   logic [2:0] out_reg1;
   logic [7:0] out_result1;
`ifdef EX_WB_FWD_EN
   logic       fwd_a_hit, fwd_b_hit, fwd_a_hit1, fwd_b_hit1;
   logic [7:0] fwd_a_data, fwd_b_data, fwd_a_data1, fwd_b_data1;
`endif

   int     checks = 0;
   int     passes = 0;
   entry_t sb[$];

   always #5 clk = ~clk;

   ex_wb_elastic #(.DATA_W(8), .RADDR_W(3), .ZERO_REG(1)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_regwrite(in_regwrite),
      .in_reg(in_reg), .in_result(in_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_regwrite(out_regwrite),
      .out_reg(out_reg), .out_result(out_result)
`ifdef EX_WB_FWD_EN
      , .src_a(src_a), .src_b(src_b), .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
      .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data)
`endif
   );

   ex_wb_elastic #(.DATA_W(8), .RADDR_W(3), .ZERO_REG(0)) dut_nz (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready1), .in_regwrite(in_regwrite),
      .in_reg(in_reg), .in_result(in_result),
      .out_valid(out_valid1), .out_ready(out_ready), .out_regwrite(out_regwrite1),
      .out_reg(out_reg1), .out_result(out_result1)
`ifdef EX_WB_FWD_EN
      , .src_a(src_a), .src_b(src_b), .fwd_a_hit(fwd_a_hit1), .fwd_b_hit(fwd_b_hit1),
      .fwd_a_data(fwd_a_data1), .fwd_b_data(fwd_b_data1)
`endif
   );

   // One clock: scoreboard pops/pushes on the transfers the next edge performs, then
   // returns 1 time unit after that edge where the tests drive and inspect.
   task automatic step_cycle();
      entry_t e;
      @(negedge clk);
      if (!rst || flush) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               $display("FAIL sb_pop: got res=%h reg=%0d we=%b, required no output", out_result, out_reg, out_regwrite);
            end else begin
               e = sb.pop_front();
               if ({out_regwrite, out_reg, out_result} !== e)
                  $display("FAIL sb_pop: got we=%b reg=%0d res=%h, required we=%b reg=%0d res=%h",
                           out_regwrite, out_reg, out_result, e.we, e.rd, e.res);
               else passes++;
            end
         end
         if (in_valid && in_ready) begin
            e.we  = in_regwrite && (in_reg != 3'd0);
            e.rd  = in_reg;
            e.res = in_result;
            sb.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic we, input logic [2:0] rd, input logic [7:0] res);
      in_valid = v; in_regwrite = we; in_reg = rd; in_result = res;
   endtask

   task automatic test_reset();
      step_cycle(); step_cycle();
      checks++;
      if ({out_valid, out_regwrite, out_reg, out_result, in_ready} !== {1'b0, 1'b0, 3'd0, 8'd0, 1'b1})
         $display("FAIL reset_init: got v=%b we=%b reg=%0d res=%h rdy=%b, required 0 0 0 00 1",
                  out_valid, out_regwrite, out_reg, out_result, in_ready);
      else passes++;
      rst = 1'b1;
      out_ready = 1'b0;
      step_cycle();
      drive(1, 1, 3'd5, 8'h77); step_cycle();
      drive(1, 1, 3'd6, 8'h66); step_cycle();
      drive(0, 0, 3'd0, 8'h00);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0)
         $display("FAIL reset_prefill: got v=%b rdy=%b, required v=1 rdy=0", out_valid, in_ready);
      else passes++;
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_regwrite, out_reg, out_result, in_ready} !== {1'b0, 1'b0, 3'd0, 8'd0, 1'b1})
         $display("FAIL reset_async: got v=%b we=%b reg=%0d res=%h rdy=%b, required 0 0 0 00 1",
                  out_valid, out_regwrite, out_reg, out_result, in_ready);
      else passes++;
      drive(1, 1, 3'd2, 8'hEE);
      step_cycle();
      checks++;
      if (out_valid !== 1'b0)
         $display("FAIL reset_ignore_in: got out_valid=%b, required 0", out_valid);
      else passes++;
      drive(0, 0, 3'd0, 8'h00);
      rst = 1'b1;
      step_cycle();
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) begin
            checks++;
            if (out_valid !== 1'b1 || out_result !== 8'(i - 1))
               $display("FAIL stream_latency: got v=%b res=%h, required v=1 res=%h", out_valid, out_result, 8'(i - 1));
            else passes++;
         end
         checks++;
         if (in_ready !== 1'b1)
            $display("FAIL stream_in_ready: got %b, required 1 at i=%0d", in_ready, i);
         else passes++;
         drive(1, (i != 5), 3'(i % 8), 8'(i));
         step_cycle();
      end
      drive(0, 0, 3'd0, 8'h00);
      checks++;
      if (out_result !== 8'd9)
         $display("FAIL stream_last: got %h, required 09", out_result);
      else passes++;
      step_cycle();
      checks++;
      if (out_valid !== 1'b0 || sb.size() != 0)
         $display("FAIL stream_drain: got v=%b pending=%0d, required v=0 pending=0", out_valid, sb.size());
      else passes++;
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(1, 1, 3'd1, 8'h11); step_cycle();
      drive(1, 1, 3'd2, 8'h22); step_cycle();
      drive(0, 0, 3'd0, 8'h00);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 8'h11)
         $display("FAIL bp_full: got rdy=%b v=%b res=%h, required rdy=0 v=1 res=11", in_ready, out_valid, out_result);
      else passes++;
      step_cycle();
      checks++;
      if (in_ready !== 1'b0 || out_result !== 8'h11)
         $display("FAIL bp_hold: got rdy=%b res=%h, required rdy=0 res=11", in_ready, out_result);
      else passes++;
      out_ready = 1'b1;
      step_cycle();
      checks++;
      if (out_valid !== 1'b1 || out_result !== 8'h22 || in_ready !== 1'b1)
         $display("FAIL bp_second: got v=%b res=%h rdy=%b, required v=1 res=22 rdy=1", out_valid, out_result, in_ready);
      else passes++;
      step_cycle();
      checks++;
      if (out_valid !== 1'b0 || sb.size() != 0)
         $display("FAIL bp_drain: got v=%b pending=%0d, required v=0 pending=0", out_valid, sb.size());
      else passes++;
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive(1, 1, 3'd4, 8'h44); step_cycle();
      drive(1, 1, 3'd5, 8'h55); step_cycle();
      drive(1, 1, 3'd3, 8'h33);
      flush = 1'b1;
      step_cycle();
      flush = 1'b0;
      drive(0, 0, 3'd0, 8'h00);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_regwrite !== 1'b0)
         $display("FAIL flush_two: got v=%b rdy=%b we=%b, required v=0 rdy=1 we=0", out_valid, in_ready, out_regwrite);
      else passes++;
      out_ready = 1'b1;
      step_cycle(); step_cycle();
      checks++;
      if (out_valid !== 1'b0)
         $display("FAIL flush_no_ghost: got out_valid=%b res=%h, required 0", out_valid, out_result);
      else passes++;
      drive(1, 1, 3'd6, 8'h66); step_cycle();
      drive(1, 1, 3'd7, 8'h77);
      flush = 1'b1;
      step_cycle();
      flush = 1'b0;
      drive(0, 0, 3'd0, 8'h00);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL flush_one: got v=%b rdy=%b, required v=0 rdy=1", out_valid, in_ready);
      else passes++;
      step_cycle();
      checks++;
      if (out_valid !== 1'b0 || sb.size() != 0)
         $display("FAIL flush_drop_input: got v=%b pending=%0d, required v=0 pending=0", out_valid, sb.size());
      else passes++;
   endtask

   task automatic test_zero_reg();
      out_ready = 1'b0;
      drive(1, 1, 3'd0, 8'hFF); step_cycle();
      drive(0, 0, 3'd0, 8'h00);
      checks++;
      if (out_valid !== 1'b1 || out_regwrite !== 1'b0 || out_result !== 8'hFF)
         $display("FAIL zero_reg_on: got v=%b we=%b res=%h, required v=1 we=0 res=ff", out_valid, out_regwrite, out_result);
      else passes++;
      checks++;
      if ({out_valid1, out_regwrite1, out_reg1, out_result1, in_ready1} !== {1'b1, 1'b1, 3'd0, 8'hFF, 1'b1})
         $display("FAIL zero_reg_off: got v=%b we=%b reg=%0d res=%h rdy=%b, required 1 1 0 ff 1",
                  out_valid1, out_regwrite1, out_reg1, out_result1, in_ready1);
      else passes++;
      out_ready = 1'b1;
      step_cycle();
   endtask

`ifdef EX_WB_FWD_EN
   task automatic test_forwarding();
      out_ready = 1'b0;
      src_a = 3'd3; src_b = 3'd4;
      drive(1, 1, 3'd3, 8'h5A); step_cycle();
      drive(0, 0, 3'd0, 8'h00);
      checks++;
      if ({fwd_a_hit, fwd_a_data, fwd_b_hit, fwd_b_data} !== {1'b1, 8'h5A, 1'b0, 8'h00})
         $display("FAIL fwd_basic: got a=%b/%h b=%b/%h, required 1/5a 0/00", fwd_a_hit, fwd_a_data, fwd_b_hit, fwd_b_data);
      else passes++;
      checks++;
      if ({fwd_a_hit1, fwd_a_data1, fwd_b_hit1, fwd_b_data1} !== {1'b1, 8'h5A, 1'b0, 8'h00})
         $display("FAIL fwd_nz: got a=%b/%h b=%b/%h, required 1/5a 0/00", fwd_a_hit1, fwd_a_data1, fwd_b_hit1, fwd_b_data1);
      else passes++;
      out_ready = 1'b1;
      step_cycle();
      checks++;
      if (fwd_a_hit !== 1'b0 || fwd_a_data !== 8'h00)
         $display("FAIL fwd_empty: got a=%b/%h, required 0/00", fwd_a_hit, fwd_a_data);
      else passes++;
   endtask
`endif

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_zero_reg();
`ifdef EX_WB_FWD_EN
      test_forwarding();
`endif
      checks++;
      if (sb.size() != 0 || out_valid !== 1'b0)
         $display("FAIL final_drain: got pending=%0d v=%b, required 0 0", sb.size(), out_valid);
      else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
